sf_tone_source: RTL and testbench

Dual-channel single-frequency test-tone transmitter: produces the sample stream the phase/magnitude computing cascade consumes (`o_vld`, `x1`, `x2`). Generates frames of `FRAME_LENGTH` samples. Each frame holds exactly one sine period on both channels, with channel 2 offset by a programmable number of samples. Used as the on-chip stimulus source for cascade bring-up, with a programmable inter-sample gap so both the burst and the decimated valid cadence can be exercised.

---
 rtl/sf_tone_source.sv | 204 ++++++++++++++++++++
 tb/tb_sf_tone_source.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sf_tone_source.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sf_tone_source                                                             |
// | Dual-channel single-frequency test-tone source: one sine period per frame, |
// | channel 2 leads by a programmable number of samples, programmable gap.     |
// | Optional build macro SF_SRC_RAMP_EN replaces the sine ROM by ramp counters.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sf_tone_source #(
    parameter int X_WIDTH      = 16,
    parameter int FRAME_LENGTH = 33,
    parameter int CNT_WIDTH    = 16,
    parameter int PH_WIDTH     = $clog2(FRAME_LENGTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [CNT_WIDTH-1:0]       n_frames,
    input  logic [7:0]                 gap,
    input  logic [PH_WIDTH-1:0]        ph_off,
    input  logic [3:0]                 amp_shift,
    output logic                       o_vld,
    output logic signed [X_WIDTH-1:0]  x1,
    output logic signed [X_WIDTH-1:0]  x2,
    output logic                       frame_start,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [PH_WIDTH:0]    c_fl       = (PH_WIDTH+1)'(FRAME_LENGTH);
    localparam logic [PH_WIDTH:0]    c_last_k   = (PH_WIDTH+1)'(FRAME_LENGTH - 1);
    localparam logic [PH_WIDTH-1:0]  c_k_one    = PH_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [PH_WIDTH-1:0]    r_k;
    logic [CNT_WIDTH-1:0]   r_frame_cnt;
    logic [CNT_WIDTH-1:0]   r_n_frames;
    logic [7:0]             r_gap;
    logic [7:0]             r_gcnt;
    logic                   w_accept;
    logic                   w_emit;
    logic                   w_k_wrap;
    logic                   w_last;

    // A start coinciding with the done pulse is dropped; restart is legal one cycle later.
    assign w_accept = (r_state == S_IDLE) && start && !abort && !done;
    assign w_emit   = (r_state == S_EMIT) && !abort;
    assign w_k_wrap = ({1'b0, r_k} == c_last_k);
    assign w_last   = w_k_wrap && (r_frame_cnt == (r_n_frames - c_cnt_one));

`ifdef SF_SRC_RAMP_EN
    logic [X_WIDTH-1:0] r_ramp1;
    logic [X_WIDTH-1:0] r_ramp2;
    logic               w_unused_cfg;

    assign w_unused_cfg = ^{ph_off, amp_shift};
`else
    localparam real c_pi = 3.14159265358979323846;

    logic [PH_WIDTH-1:0]        r_ph;
    logic [3:0]                 r_shift;
    logic [PH_WIDTH:0]          w_ph_ext;
    logic [PH_WIDTH:0]          w_sum;
    logic [PH_WIDTH-1:0]        w_idx2;
    logic signed [X_WIDTH-1:0]  w_rom [FRAME_LENGTH];

    function automatic logic signed [X_WIDTH-1:0] sine_entry(input int k);
        real a;
        a = real'((64'd1 << (X_WIDTH - 1)) - 64'd1)
            * $sin(2.0 * c_pi * real'(k) / real'(FRAME_LENGTH));
        if (a >= 0.0) begin
            return X_WIDTH'($rtoi(a + 0.5));
        end
        return X_WIDTH'($rtoi(a - 0.5));
    endfunction

    generate
        for (genvar gi = 0; gi < FRAME_LENGTH; gi++) begin : g_rom
            assign w_rom[gi] = sine_entry(gi);
        end
    endgenerate

    assign w_ph_ext = {1'b0, ph_off};
    assign w_sum    = {1'b0, r_k} + {1'b0, r_ph};
    assign w_idx2   = (w_sum >= c_fl) ? PH_WIDTH'(w_sum - c_fl) : PH_WIDTH'(w_sum);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (n_frames == '0) ? S_DONE : S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else if (r_gap == 8'd0) begin
                    w_state_nxt = S_EMIT;
                end else begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gcnt == r_gap) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_vld       <= 1'b0;
            x1          <= '0;
            x2          <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            r_k         <= '0;
            r_frame_cnt <= '0;
            r_n_frames  <= '0;
            r_gap       <= '0;
            r_gcnt      <= '0;
`ifdef SF_SRC_RAMP_EN
            r_ramp1     <= '0;
            r_ramp2     <= '0;
`else
            r_ph        <= '0;
            r_shift     <= '0;
`endif
        end else begin
            // Outputs trail the state by one register stage.
            o_vld       <= w_emit;
            frame_start <= w_emit && (r_k == '0);
            done        <= (r_state == S_DONE) && !abort;
            busy        <= (r_state != S_IDLE) && !abort;

            if (w_accept) begin
                r_n_frames  <= n_frames;
                r_gap       <= gap;
                r_k         <= '0;
                r_frame_cnt <= '0;
`ifdef SF_SRC_RAMP_EN
                r_ramp1     <= X_WIDTH'(1);
                r_ramp2     <= X_WIDTH'(2);
`else
                r_ph        <= (w_ph_ext >= c_fl) ? PH_WIDTH'(w_ph_ext - c_fl) : ph_off;
                r_shift     <= amp_shift;
`endif
            end

            if (w_emit) begin
`ifdef SF_SRC_RAMP_EN
                x1      <= $signed(r_ramp1);
                x2      <= $signed(r_ramp2);
                r_ramp1 <= r_ramp1 + X_WIDTH'(1);
                r_ramp2 <= r_ramp2 + X_WIDTH'(2);
`else
                x1      <= w_rom[r_k] >>> r_shift;
                x2      <= w_rom[w_idx2] >>> r_shift;
`endif
                if (w_k_wrap) begin
                    r_k         <= '0;
                    r_frame_cnt <= r_frame_cnt + c_cnt_one;
                end else begin
                    r_k         <= r_k + c_k_one;
                end
            end

            if (r_state == S_EMIT) begin
                r_gcnt <= 8'd1;
            end else if (r_state == S_GAP) begin
                r_gcnt <= r_gcnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sf_tone_source.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sf_tone_source                                                          |
// | Randomized bench for sf_tone_source with a behavioural timeline model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sf_tone_source;

    localparam int FL  = 33;
    localparam int XW  = 16;
    localparam int CW  = 16;
    localparam int PHW = $clog2(FL);
    localparam int NEVER = 32'h7fff_ffff;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [CW-1:0]  n_frames = '0;
    logic [7:0]     gap = '0;
    logic [PHW-1:0] ph_off = '0;
    logic [3:0]     amp_shift = '0;
    logic o_vld, frame_start, busy, done;
    logic signed [XW-1:0] x1, x2;

    sf_tone_source #(
        .X_WIDTH(XW), .FRAME_LENGTH(FL), .CNT_WIDTH(CW), .PH_WIDTH(PHW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .n_frames(n_frames), .gap(gap), .ph_off(ph_off), .amp_shift(amp_shift),
        .o_vld(o_vld), .x1(x1), .x2(x2), .frame_start(frame_start),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    logic rst_q = 1'b1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model of the current run: start cycle, config, and cycle of abort/reset.
    bit m_valid = 1'b0;
    int m_ts = 0, m_ab = NEVER, m_n = 0, m_g = 0, m_phr = 0, m_sh = 0;

    function automatic int sine_ref(input int k);
        real a;
        a = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(FL));
        return (a >= 0.0) ? $rtoi(a + 0.5) : $rtoi(a - 0.5);
    endfunction

    // Expected outputs visible in cycle t: samples every gap+1 cycles starting two
    // cycles after the start-driving cycle, then one done cycle.
    function automatic void model_at(input int t, output bit vld, output bit fs,
                                     output bit bsy, output bit dn, output int idx);
        int rel, per, last;
        vld = 0; fs = 0; bsy = 0; dn = 0; idx = 0;
        if (!m_valid || t > m_ab) return;
        rel = t - m_ts - 2;
        if (rel < 0) return;
        per = m_g + 1;
        if (m_n == 0) begin
            if (rel == 0) begin dn = 1; bsy = 1; end
            return;
        end
        last = (m_n * FL - 1) * per;
        if (rel <= last) begin
            bsy = 1;
            if (rel % per == 0) begin
                vld = 1; idx = rel / per; fs = ((idx % FL) == 0);
            end
        end else if (rel == last + 1) begin
            dn = 1; bsy = 1;
        end
    endfunction

    function automatic int run_end();
        int e;
        if (!m_valid) return cyc;
        e = (m_n == 0) ? m_ts + 2 : m_ts + 2 + (m_n * FL - 1) * (m_g + 1) + 1;
        return (m_ab < e) ? m_ab : e;
    endfunction

    logic signed [XW-1:0] ex1 = '0, ex2 = '0;
    logic signed [XW-1:0] vx1[$], vx2[$];
    int fscnt = 0, dcnt = 0;

    always @(negedge clk) begin
        bit e_vld, e_fs, e_busy, e_done;
        int e_idx, k;
        if (chk_en) begin
            if (rst_q) begin
                e_vld = 0; e_fs = 0; e_busy = 0; e_done = 0; e_idx = 0;
                ex1 = '0; ex2 = '0;
            end else begin
                model_at(cyc, e_vld, e_fs, e_busy, e_done, e_idx);
                if (e_vld) begin
`ifdef SF_SRC_RAMP_EN
                    k   = e_idx + 1;
                    ex1 = XW'(k);
                    ex2 = XW'(2 * k);
`else
                    k   = e_idx % FL;
                    ex1 = XW'(sine_ref(k) >>> m_sh);
                    ex2 = XW'(sine_ref((k + m_phr) % FL) >>> m_sh);
`endif
                end
            end
            checks++;
            if (o_vld !== e_vld || frame_start !== e_fs || busy !== e_busy ||
                done !== e_done || x1 !== ex1 || x2 !== ex2) begin
                errors++;
                $display("FAIL cycle %0d outputs: got vld=%b fs=%b busy=%b done=%b x1=%0d x2=%0d, expected vld=%b fs=%b busy=%b done=%b x1=%0d x2=%0d",
                         cyc, o_vld, frame_start, busy, done, x1, x2,
                         e_vld, e_fs, e_busy, e_done, ex1, ex2);
            end
            if (o_vld === 1'b1) begin
                vx1.push_back(x1);
                vx2.push_back(x2);
                if (frame_start === 1'b1) fscnt++;
            end
            if (done === 1'b1) dcnt++;
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    function automatic int got_x(input bit ch2, input int i);
        if (i < 0 || i >= vx1.size()) return 999999;
        return ch2 ? int'(vx2[i]) : int'(vx1[i]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input int n, input int g, input int ph, input int sh,
                               input bit with_abort);
        bit v, f, b_next, d_now, dummy;
        int ix;
        n_frames = CW'(n); gap = 8'(g); ph_off = PHW'(ph); amp_shift = 4'(sh);
        start = 1'b1;
        abort = with_abort;
        model_at(cyc + 1, v, f, b_next, dummy, ix);
        model_at(cyc, v, f, dummy, d_now, ix);
        if (with_abort) begin
            if (m_ab > cyc) m_ab = cyc;
        end else if (!b_next && !d_now) begin
            m_valid = 1; m_ts = cyc; m_ab = NEVER;
            m_n = n; m_g = g; m_phr = (ph >= FL) ? ph - FL : ph; m_sh = sh;
        end
        tick();
        start = 1'b0;
        abort = 1'b0;
        n_frames = CW'($urandom_range(0, 7)); gap = 8'($urandom);
        ph_off = PHW'($urandom); amp_shift = 4'($urandom);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        if (m_ab > cyc) m_ab = cyc;
        tick();
        abort = 1'b0;
    endtask

    task automatic wait_run();
        int e;
        e = run_end();
        while (cyc <= e + 1) tick();
    endtask

    int v0, f0, d0, t10, e;

    task automatic mark();
        v0 = vx1.size(); f0 = fscnt; d0 = dcnt;
    endtask

    initial begin
        rst = 1'b1;
        tick(); tick();
        chk_en = 1'b1;
        tick();
        m_ab = cyc;
        rst = 1'b0;
        tick(); tick();

        check("model_rom0", sine_ref(0), 0);
        check("model_rom8", sine_ref(8), 32730);

        // Single frame, back-to-back samples.
        mark();
        issue_start(1, 0, 0, 0, 1'b0);
        wait_run();
        check("t1_valids", vx1.size() - v0, 33);
        check("t1_frame_starts", fscnt - f0, 1);
        check("t1_done", dcnt - d0, 1);
`ifdef SF_SRC_RAMP_EN
        check("t1_ramp_x1_first", got_x(0, v0), 1);
        check("t1_ramp_x2_first", got_x(1, v0), 2);
        check("t1_ramp_x1_last", got_x(0, v0 + 32), 33);
        check("t1_ramp_x2_last", got_x(1, v0 + 32), 66);
`else
        check("t1_x1_first", got_x(0, v0), 0);
        check("t1_x2_first", got_x(1, v0), 0);
        check("t1_x1_k8", got_x(0, v0 + 8), 32730);
`endif

        // Two frames, gap 8, channel 2 leading by 8.
        tick();
        mark();
        issue_start(2, 8, 8, 0, 1'b0);
        wait_run();
        check("t2_valids", vx1.size() - v0, 66);
        check("t2_frame_starts", fscnt - f0, 2);
`ifndef SF_SRC_RAMP_EN
        check("t2_x2_first", got_x(1, v0), 32730);

        // Amplitude shift with sign extension.
        mark();
        issue_start(1, 1, 0, 4, 1'b0);
        wait_run();
        check("t3_x1_k8", got_x(0, v0 + 8), 2045);
        check("t3_x1_k20_negative", int'(got_x(0, v0 + 20) < 0), 1);
`endif

        // Zero frames, then a start while busy, then a start in the done cycle.
        mark();
        issue_start(0, 0, 0, 0, 1'b0);
        wait_run();
        check("t4_zero_valids", vx1.size() - v0, 0);
        check("t4_zero_done", dcnt - d0, 1);
        mark();
        issue_start(1, 2, 3, 1, 1'b0);
        repeat (20) tick();
        issue_start(3, 0, 0, 0, 1'b0);
        e = run_end();
        while (cyc < e) tick();
        issue_start(2, 0, 0, 0, 1'b0);
        issue_start(0, 0, 0, 0, 1'b0);
        wait_run();
        check("t4_busy_start_valids", vx1.size() - v0, 33);
        check("t4_done_pulses", dcnt - d0, 2);

        // Abort on the 10th valid of a 3-frame run, then restart.
        mark();
        issue_start(3, 1, 5, 0, 1'b0);
        t10 = m_ts + 2 + 9 * (m_g + 1);
        while (cyc < t10) tick();
        do_abort();
        repeat (6) tick();
        check("t5_abort_valids", vx1.size() - v0, 10);
        check("t5_abort_no_done", dcnt - d0, 0);
        mark();
        issue_start(1, 0, 0, 0, 1'b0);
        wait_run();
        check("t5_restart_valids", vx1.size() - v0, 33);
        check("t5_restart_fs", fscnt - f0, 1);

        // Abort and start together while idle: abort wins.
        mark();
        issue_start(1, 0, 0, 0, 1'b1);
        repeat (5) tick();
        check("t6_abort_start_valids", vx1.size() - v0, 0);

        // Reset in mid-stream discards the run.
        issue_start(2, 0, 7, 2, 1'b0);
        repeat (40) tick();
        rst = 1'b1;
        if (m_ab > cyc) m_ab = cyc;
        tick(); tick();
        rst = 1'b0;
        tick();
        mark();
        issue_start(1, 0, 0, 0, 1'b0);
        wait_run();
        check("t7_after_reset_valids", vx1.size() - v0, 33);

        // Randomized runs with stray start/abort pulses.
        for (int r = 0; r < 12; r++) begin
            issue_start($urandom_range(0, 2), $urandom_range(0, 3),
                        $urandom_range(0, 63), $urandom_range(0, 15), 1'b0);
            for (int it = 0; it < 3000 && cyc <= run_end() + 1; it++) begin
                int p;
                p = $urandom_range(0, 199);
                if (p < 3) begin
                    issue_start($urandom_range(0, 2), $urandom_range(0, 3),
                                $urandom_range(0, 63), $urandom_range(0, 15),
                                ($urandom_range(0, 3) == 0));
                end else if (p == 3) begin
                    do_abort();
                end else begin
                    tick();
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got cycle budget exhausted at cycle %0d, expected completion earlier", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
